// File: rtl/fetch_pkg.sv
// Shared types and constants for the IF stage: NOP encoding, FSM states, IF/ID bubble.
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
  localparam logic [31:0] CNT_MAX   = 32'hFFFF_FFFF;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // IF/ID contents loaded on reset, boot and flush; the PC field is always zero.
  typedef struct packed {
    logic        valid;
    logic [31:0] instr;
  } ifid_bubble_t;

  localparam ifid_bubble_t IFID_BUBBLE = '{valid: 1'b0, instr: NOP_INSTR};

endpackage

// File: rtl/fetch_perf_cnt.sv
// Two saturating event counters (taken redirects, stall cycles), cleared by sync active-low reset.
module fetch_perf_cnt
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_redir,
  input  logic        i_stall,
  output logic [31:0] o_redir_cnt,
  output logic [31:0] o_stall_cnt
);

  logic [31:0] r_redir_cnt;
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_redir_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (i_redir && (r_redir_cnt != CNT_MAX)) r_redir_cnt <= r_redir_cnt + 32'd1;
      if (i_stall && (r_stall_cnt != CNT_MAX)) r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign o_redir_cnt = r_redir_cnt;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC mux (redirect > stall > +4) and IF/ID latch with flush.
// Optional saturating perf counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              PC_W     = 9,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  output logic [PC_W-1:0] Instr_Addr,
  input  logic [31:0]     Instr_Data,
  output logic [PC_W-1:0] IfId_PC,
  output logic [31:0]     IfId_Instr,
  output logic            IfId_Valid,
  output logic            Flush
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     Redir_Cnt,
  output logic [31:0]     Stall_Cnt
`endif
);

  fetch_state_e    r_state;
  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_ifid_pc;
  logic [31:0]     r_ifid_instr;
  logic            r_ifid_valid;

  logic            w_run;
  logic [PC_W-1:0] w_pc_inc;
  logic [PC_W-1:0] w_br_tgt;
  logic            w_unused_br;

  assign w_run    = (r_state == RUN);
  assign w_pc_inc = r_pc + PC_W'(4);
  // Target is word aligned and truncated to the instruction-memory range.
  assign w_br_tgt = {BrPC[PC_W-1:2], 2'b00};
  assign w_unused_br = ^{BrPC[31:PC_W], BrPC[1:0]};

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= BOOT;
      r_pc         <= RESET_PC;
      r_ifid_pc    <= '0;
      r_ifid_instr <= IFID_BUBBLE.instr;
      r_ifid_valid <= IFID_BUBBLE.valid;
    end else begin
      case (r_state)
        BOOT: begin
          // The RESET_PC slot is deliberately dropped as a boot bubble.
          r_state      <= RUN;
          r_pc         <= w_pc_inc;
          r_ifid_pc    <= '0;
          r_ifid_instr <= IFID_BUBBLE.instr;
          r_ifid_valid <= IFID_BUBBLE.valid;
        end
        RUN: begin
          if (PcSel) begin
            r_pc         <= w_br_tgt;
            r_ifid_pc    <= '0;
            r_ifid_instr <= IFID_BUBBLE.instr;
            r_ifid_valid <= IFID_BUBBLE.valid;
          end else if (!Stall) begin
            r_pc         <= w_pc_inc;
            r_ifid_pc    <= r_pc;
            r_ifid_instr <= Instr_Data;
            r_ifid_valid <= 1'b1;
          end
        end
        default: r_state <= BOOT;
      endcase
    end
  end

  assign Instr_Addr = r_pc;
  assign IfId_PC    = r_ifid_pc;
  assign IfId_Instr = r_ifid_instr;
  assign IfId_Valid = r_ifid_valid;
  assign Flush      = reset & w_run & PcSel;

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_cnt u_perf (
    .clk         (clk),
    .reset       (reset),
    .i_redir     (w_run & PcSel),
    .i_stall     (w_run & Stall & ~PcSel),
    .o_redir_cnt (Redir_Cnt),
    .o_stall_cnt (Stall_Cnt)
  );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: reference model pushes expected IF/ID state, popped after each edge.
module tb_fetch_stage;

  localparam int PC_W = 9;

  logic            clk = 1'b0;
  logic            reset;
  logic            Stall;
  logic            PcSel;
  logic [31:0]     BrPC;
  logic [PC_W-1:0] Instr_Addr;
  logic [31:0]     Instr_Data;
  logic [PC_W-1:0] IfId_PC;
  logic [31:0]     IfId_Instr;
  logic            IfId_Valid;
  logic            Flush;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]     Redir_Cnt;
  logic [31:0]     Stall_Cnt;
`endif

  always #5 clk = ~clk;

  // Instruction memory: mem[a] = a | 1.
  assign Instr_Data = 32'(Instr_Addr) | 32'h1;

  fetch_stage #(.PC_W(PC_W), .RESET_PC('0)) dut (
    .clk        (clk),
    .reset      (reset),
    .Stall      (Stall),
    .PcSel      (PcSel),
    .BrPC       (BrPC),
    .Instr_Addr (Instr_Addr),
    .Instr_Data (Instr_Data),
    .IfId_PC    (IfId_PC),
    .IfId_Instr (IfId_Instr),
    .IfId_Valid (IfId_Valid),
    .Flush      (Flush)
`ifdef FETCH_PERF_CNT_EN
    ,
    .Redir_Cnt  (Redir_Cnt),
    .Stall_Cnt  (Stall_Cnt)
`endif
  );

  typedef struct {
    logic [PC_W-1:0] addr;
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            valid;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  logic [PC_W-1:0] m_pc;
  logic            m_run;
  exp_t            m_ifid;
  int unsigned     m_redir;
  int unsigned     m_stall;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_pop(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_addr"},  32'(Instr_Addr), 32'(e.addr));
      chk({tag, "_pc"},    32'(IfId_PC),    32'(e.pc));
      chk({tag, "_instr"}, IfId_Instr,      e.instr);
      chk({tag, "_valid"}, 32'(IfId_Valid), 32'(e.valid));
    end
  endtask

  function automatic exp_t bubble();
    exp_t b;
    b.addr = '0; b.pc = '0; b.instr = 32'h0000_0013; b.valid = 1'b0;
    return b;
  endfunction

  // One clock of stimulus; called just after a rising edge.
  task automatic step(input string tag, input logic st, input logic ps, input logic [31:0] br);
    exp_t e;
    Stall = st; PcSel = ps; BrPC = br;
    #1;
    chk({tag, "_flush"}, 32'(Flush), 32'(m_run & ps));
    if (!m_run) begin
      e = bubble();
      m_pc = m_pc + 9'd4;
      m_run = 1'b1;
    end else if (ps) begin
      e = bubble();
      m_pc = {br[PC_W-1:2], 2'b00};
      m_redir++;
    end else if (st) begin
      e = m_ifid;
      m_stall++;
    end else begin
      e.pc = m_pc; e.instr = 32'(m_pc) | 32'h1; e.valid = 1'b1;
      m_pc = m_pc + 9'd4;
    end
    e.addr = m_pc;
    m_ifid = e;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_pop(tag);
  endtask

  task automatic do_reset(input string tag, input logic ps);
    reset = 1'b0; Stall = 1'b0; PcSel = ps; BrPC = 32'h0000_0100;
    repeat (2) @(posedge clk);
    #1;
    m_pc = '0; m_run = 1'b0; m_ifid = bubble(); m_redir = 0; m_stall = 0;
    sb.push_back(m_ifid);
    check_pop(tag);
    chk({tag, "_flush"}, 32'(Flush), 32'd0);
    reset = 1'b1; PcSel = 1'b0;
  endtask

  initial begin
    reset = 1'b0; Stall = 1'b0; PcSel = 1'b0; BrPC = '0;
    m_pc = '0; m_run = 1'b0; m_ifid = bubble(); m_redir = 0; m_stall = 0;
    @(posedge clk); #1;

    // 1: reset, boot bubble, first valid fetch
    do_reset("rst", 1'b0);
    step("boot", 1'b0, 1'b0, 32'h0);
    chk("boot_addr4", 32'(Instr_Addr), 32'h004);
    step("run1", 1'b0, 1'b0, 32'h0);
    chk("run1_valid", 32'(IfId_Valid), 32'd1);

    // 2: straight-line run through the 0x1FC -> 0x000 wrap
    for (int i = 0; i < 130; i++) step("run", 1'b0, 1'b0, 32'h0);

    // 3: redirect with unaligned target
    step("redir", 1'b0, 1'b1, 32'h0000_0043);
    chk("redir_tgt", 32'(Instr_Addr), 32'h040);
    step("tgt0", 1'b0, 1'b0, 32'h0);
    step("tgt1", 1'b0, 1'b0, 32'h0);

    // 4: stall hold, then stall together with redirect
    for (int i = 0; i < 3; i++) step("stall", 1'b1, 1'b0, 32'h0);
    step("stall_redir", 1'b1, 1'b1, 32'h0000_0100);
    step("after_sr", 1'b0, 1'b0, 32'h0);

    // back-to-back redirects; upper target bits truncated, then wrap
    step("b2b_a", 1'b0, 1'b1, 32'h0000_0080);
    step("b2b_b", 1'b0, 1'b1, 32'hFFFF_FFF7);
    chk("b2b_tgt", 32'(Instr_Addr), 32'h1F4);
    for (int i = 0; i < 4; i++) step("b2b_run", 1'b0, 1'b0, 32'h0);

    // 5: reset in the cycle of a redirect
    Stall = 1'b0; PcSel = 1'b1; BrPC = 32'h0000_0080; reset = 1'b0;
    #1;
    chk("rst_redir_flush", 32'(Flush), 32'd0);
    do_reset("rst_redir", 1'b1);
    PcSel = 1'b1; reset = 1'b1;
    #1;
    chk("boot_flush", 32'(Flush), 32'd0);
    step("boot2", 1'b0, 1'b1, 32'h0000_0080);
    step("run2", 1'b0, 1'b0, 32'h0);

`ifdef FETCH_PERF_CNT_EN
    // 6: counters
    do_reset("rst_cnt", 1'b0);
    chk("cnt_rst_redir", Redir_Cnt, 32'd0);
    chk("cnt_rst_stall", Stall_Cnt, 32'd0);
    step("cboot", 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      step("cred", 1'b0, 1'b1, 32'(i * 16));
      step("cst", (i < 4) ? 1'b1 : 1'b0, 1'b0, 32'h0);
    end
    step("cst5", 1'b1, 1'b0, 32'h0);
    step("cst6", 1'b1, 1'b0, 32'h0);
    step("cst7", 1'b1, 1'b0, 32'h0);
    chk("cnt_redir5", Redir_Cnt, m_redir);
    chk("cnt_stall7", Stall_Cnt, m_stall);
    chk("cnt_redir_const", Redir_Cnt, 32'd5);
    chk("cnt_stall_const", Stall_Cnt, 32'd7);
    dut.u_perf.r_redir_cnt = 32'hFFFF_FFFF;
    dut.u_perf.r_stall_cnt = 32'hFFFF_FFFF;
    step("sat_r", 1'b0, 1'b1, 32'h0);
    step("sat_s", 1'b1, 1'b0, 32'h0);
    chk("cnt_redir_sat", Redir_Cnt, 32'hFFFF_FFFF);
    chk("cnt_stall_sat", Stall_Cnt, 32'hFFFF_FFFF);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
